// File: rtl/mod_exp_ctrl.sv
// mod_exp_ctrl: left-to-right square-and-multiply sequencer for X^E mod M
// in the Montgomery domain. It drives an external Montgomery multiplier
// through a start/done handshake and does no arithmetic of its own.
// Build option: define CONVERT_OUT_EN to add a final mont(acc, 1) step,
// which returns the result in normal form instead of Montgomery form.
module mod_exp_ctrl #(
    parameter int unsigned WIDTH     = 1024,
    parameter int unsigned EXP_WIDTH = 1024,
    parameter int unsigned LEN_W     = 11
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     in_x,
    input  logic [WIDTH-1:0]     in_r,
    input  logic [WIDTH-1:0]     in_m,
    input  logic [EXP_WIDTH-1:0] in_e,
    input  logic [LEN_W-1:0]     in_elen,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     result,
    output logic                 mont_start,
    output logic [WIDTH-1:0]     mont_a,
    output logic [WIDTH-1:0]     mont_b,
    output logic [WIDTH-1:0]     mont_m,
    input  logic [WIDTH-1:0]     mont_result,
    input  logic                 mont_done
);

`ifdef CONVERT_OUT_EN
    typedef enum logic [3:0] {
        IDLE, SQ_S, SQ_W, MUL_S, MUL_W, NXT, CV_S, CV_W, FIN
    } state_t;
    // After the last exponent bit, the result is converted out of Montgomery form
    localparam state_t LOOP_DONE = CV_S;
`else
    typedef enum logic [3:0] {
        IDLE, SQ_S, SQ_W, MUL_S, MUL_W, NXT, FIN
    } state_t;
    localparam state_t LOOP_DONE = FIN;
`endif

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      x_q, x_d;
    logic [WIDTH-1:0]      m_q, m_d;
    logic [EXP_WIDTH-1:0]  e_q, e_d;
    logic [LEN_W-1:0]      idx_q, idx_d;
    logic [WIDTH-1:0]      acc_q, acc_d;
    logic [WIDTH-1:0]      result_q, result_d;
    logic [WIDTH-1:0]      mont_a_q, mont_a_d;
    logic [WIDTH-1:0]      mont_b_q, mont_b_d;
    logic                  done_q, done_d;

    logic [LEN_W-1:0]      idx_m1;
    logic [EXP_WIDTH-1:0]  e_shr;
    logic                  e_bit;

    // Select the exponent bit for the current position, e[idx-1]
    always_comb begin
        idx_m1 = idx_q - LEN_W'(1);
        e_shr  = e_q >> idx_m1;
        e_bit  = e_shr[0];
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            x_q      <= '0;
            m_q      <= '0;
            e_q      <= '0;
            idx_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            mont_a_q <= '0;
            mont_b_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            m_q      <= m_d;
            e_q      <= e_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            mont_a_q <= mont_a_d;
            mont_b_q <= mont_b_d;
            done_q   <= done_d;
        end
    end

    // Next-state sequencing of the square/multiply loop
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (in_elen == '0) ? LOOP_DONE : SQ_S;
            SQ_S:    state_d = SQ_W;
            SQ_W:    if (mont_done) state_d = e_bit ? MUL_S : NXT;
            MUL_S:   state_d = MUL_W;
            MUL_W:   if (mont_done) state_d = NXT;
            NXT:     state_d = (idx_q == LEN_W'(1)) ? LOOP_DONE : SQ_S;
`ifdef CONVERT_OUT_EN
            CV_S:    state_d = CV_W;
            CV_W:    if (mont_done) state_d = FIN;
`endif
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath updates; multiplier operands are loaded on the edge that
    // enters a *_S state, so they are already registered during the
    // mont_start cycle and stay put until the next *_S entry
    always_comb begin
        x_d      = x_q;
        m_d      = m_q;
        e_d      = e_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        result_d = result_q;
        mont_a_d = mont_a_q;
        mont_b_d = mont_b_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    x_d   = in_x;
                    m_d   = in_m;
                    e_d   = in_e;
                    idx_d = in_elen;
                    acc_d = in_r;
                end
            end
            SQ_W, MUL_W: if (mont_done) acc_d = mont_result;
`ifdef CONVERT_OUT_EN
            CV_W:        if (mont_done) acc_d = mont_result;
`endif
            NXT:         idx_d = idx_m1;
            FIN: begin
                result_d = acc_q;
                done_d   = 1'b1;
            end
            default: ;
        endcase

        if (state_d != state_q) begin
            case (state_d)
                SQ_S: begin
                    mont_a_d = acc_d;
                    mont_b_d = acc_d;
                end
                MUL_S: begin
                    mont_a_d = acc_d;
                    mont_b_d = x_q;
                end
`ifdef CONVERT_OUT_EN
                CV_S: begin
                    mont_a_d = acc_d;
                    mont_b_d = WIDTH'(1);
                end
`endif
                default: ;
            endcase
        end
    end

    // Output decode
    always_comb begin
        busy       = (state_q != IDLE);
        mont_start = (state_q == SQ_S) || (state_q == MUL_S);
`ifdef CONVERT_OUT_EN
        mont_start = mont_start || (state_q == CV_S);
`endif
        done       = done_q;
        result     = result_q;
        mont_a     = mont_a_q;
        mont_b     = mont_b_q;
        mont_m     = m_q;
    end

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Bench for mod_exp_ctrl with WIDTH=EXP_WIDTH=8, M=0xF1, R mod M=0x0F,
// X=3 (Montgomery form 0x2D) and a behavioural multiplier of latency 4.
module tb_mod_exp_ctrl;

    localparam int unsigned W   = 8;
    localparam int unsigned EW  = 8;
    localparam int unsigned LW  = 4;
    localparam int          LAT = 4;
    localparam int          M   = 241;
    localparam int          RINV = 225;   // 15 * 225 = 3375 = 14*241 + 1

`ifdef CONVERT_OUT_EN
    localparam int CV_P = 1;
    localparam int CV_L = LAT + 1;
    localparam bit NORM = 1'b1;
`else
    localparam int CV_P = 0;
    localparam int CV_L = 0;
    localparam bit NORM = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [W-1:0]  in_x, in_r, in_m;
    logic [EW-1:0] in_e;
    logic [LW-1:0] in_elen;
    logic          busy, done;
    logic [W-1:0]  result;
    logic          mont_start;
    logic [W-1:0]  mont_a, mont_b, mont_m, mont_result;
    logic          mont_done;

    always #5 clk = ~clk;

    mod_exp_ctrl #(.WIDTH(W), .EXP_WIDTH(EW), .LEN_W(LW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_x(in_x), .in_r(in_r), .in_m(in_m), .in_e(in_e), .in_elen(in_elen),
        .busy(busy), .done(done), .result(result),
        .mont_start(mont_start), .mont_a(mont_a), .mont_b(mont_b), .mont_m(mont_m),
        .mont_result(mont_result), .mont_done(mont_done)
    );

    // Behavioural Montgomery multiplier: done high LAT cycles after mont_start
    logic         stub_pend, stub_done, stray_done;
    int           stub_cnt;
    logic [W-1:0] stub_res;
    assign mont_done   = stub_done | stray_done;
    assign mont_result = stub_res;

    always @(posedge clk) begin
        if (reset) begin
            stub_pend <= 1'b0;
            stub_done <= 1'b0;
            stub_cnt  <= 0;
            stub_res  <= '0;
        end else begin
            stub_done <= 1'b0;
            if (mont_start) begin
                stub_pend <= 1'b1;
                stub_cnt  <= LAT - 1;
                stub_res  <= 8'((int'(mont_a) * int'(mont_b) * RINV) % M);
            end else if (stub_pend) begin
                if (stub_cnt == 1) begin
                    stub_done <= 1'b1;
                    stub_pend <= 1'b0;
                end else begin
                    stub_cnt <= stub_cnt - 1;
                end
            end
        end
    end

    // Handshake monitors: pulse count/width, modulus, operand stability
    int           pulse_cnt, wide_err, stab_err, m_err;
    logic         prev_ms = 1'b0;
    logic [W-1:0] lat_a = '0, lat_b = '0;

    always @(posedge clk) begin
        if (mont_start) begin
            pulse_cnt++;
            lat_a = mont_a;
            lat_b = mont_b;
            if (prev_ms) wide_err++;
            if (mont_m != 8'hF1) m_err++;
        end
        prev_ms = mont_start;
    end

    always @(negedge clk) begin
        if ((stub_pend || stub_done) && (mont_a != lat_a || mont_b != lat_b)) stab_err++;
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issue one exponentiation; optionally re-pulse start (with other inputs) mid-run
    task automatic run_op(input logic [EW-1:0] e, input logic [LW-1:0] elen,
                          input int restart_at,
                          output logic [W-1:0] res, output int lat, output int pulses);
        @(negedge clk);
        pulse_cnt = 0; wide_err = 0; stab_err = 0; m_err = 0;
        in_e = e; in_elen = elen; start = 1'b1;
        lat = -1;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (c == restart_at) begin
                start = 1'b1; in_e = 8'hFF; in_elen = 4'd8;
            end else begin
                start = 1'b0;
            end
            if (c == 1) chk("busy_after_start", busy, 1);
            if (done) begin
                lat = c;
                break;
            end
        end
        start  = 1'b0;
        res    = result;
        pulses = pulse_cnt;
    endtask

    typedef struct {
        logic [EW-1:0] e;
        logic [LW-1:0] elen;
        logic [W-1:0]  res_mont;
        logic [W-1:0]  res_norm;
        int            pulses;
        int            lat;
    } vec_t;

    vec_t         vecs[7];
    logic [W-1:0] got_res;
    int           got_lat, got_pulses;

    initial begin
        vecs[0] = '{8'h05, 4'd3, 8'h1E, 8'h02,  5, 30};
        vecs[1] = '{8'hFF, 4'd0, 8'h0F, 8'h01,  0,  2};
        vecs[2] = '{8'hFF, 4'd8, 8'h78, 8'h08, 16, 90};
        vecs[3] = '{8'hA5, 4'd4, 8'h1E, 8'h02,  6, 36};
        vecs[4] = '{8'h01, 4'd1, 8'h2D, 8'h03,  2, 13};
        vecs[5] = '{8'h80, 4'd8, 8'h57, 8'h36,  9, 55};
        vecs[6] = '{8'h00, 4'd8, 8'h0F, 8'h01,  8, 50};

        reset = 1'b1; start = 1'b0; stray_done = 1'b0;
        in_x = 8'h2D; in_r = 8'h0F; in_m = 8'hF1; in_e = '0; in_elen = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_mont_start", mont_start, 0);
        chk("rst_mont_a", mont_a, 0);
        chk("rst_mont_b", mont_b, 0);
        chk("rst_mont_m", mont_m, 0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].e, vecs[i].elen, -1, got_res, got_lat, got_pulses);
            chk($sformatf("v%0d_result", i), got_res, NORM ? vecs[i].res_norm : vecs[i].res_mont);
            chk($sformatf("v%0d_latency", i), got_lat, vecs[i].lat + CV_L);
            chk($sformatf("v%0d_pulses", i), got_pulses, vecs[i].pulses + CV_P);
            chk($sformatf("v%0d_pulse_width", i), wide_err, 0);
            chk($sformatf("v%0d_operand_stable", i), stab_err, 0);
            chk($sformatf("v%0d_mont_m", i), m_err, 0);
            @(negedge clk);
            chk($sformatf("v%0d_done_one_cycle", i), done, 0);
            chk($sformatf("v%0d_idle_busy", i), busy, 0);
            repeat (3) @(negedge clk);
            chk($sformatf("v%0d_result_held", i), result, NORM ? vecs[i].res_norm : vecs[i].res_mont);
        end

        // start re-asserted mid-run with different operands must be ignored
        run_op(8'h05, 4'd3, 10, got_res, got_lat, got_pulses);
        chk("restart_result", got_res, NORM ? 8'h02 : 8'h1E);
        chk("restart_latency", got_lat, 30 + CV_L);
        chk("restart_pulses", got_pulses, 5 + CV_P);
        @(negedge clk);
        chk("restart_no_second_run", busy, 0);

        // reset on cycle 12 of a run aborts it
        @(negedge clk);
        in_e = 8'h05; in_elen = 4'd3; start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_result", result, 0);
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("stray_busy", busy, 0);
        chk("stray_done", done, 0);
        chk("stray_result", result, 0);
        chk("stray_mont_start", mont_start, 0);

        run_op(8'h05, 4'd3, -1, got_res, got_lat, got_pulses);
        chk("after_abort_result", got_res, NORM ? 8'h02 : 8'h1E);
        chk("after_abort_latency", got_lat, 30 + CV_L);
        chk("after_abort_pulses", got_pulses, 5 + CV_P);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
